// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, FSM states and byte-lane helpers for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~off[0];
      SIZE_WORD: ok = (off == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << {off[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SIZE_BYTE: d = {4{wdata[7:0]}};
      SIZE_HALF: d = {2{wdata[15:0]}};
      default:   d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed lane of a read word and sign/zero extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    data      = rdata;
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: data = {{24{byte_lane[7] & ~load_unsigned}}, byte_lane};
      SIZE_HALF: data = {{16{half_lane[15] & ~load_unsigned}}, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - MEM-stage load/store sequencer driving one req/gnt/rvalid data-bus port
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_d_size,
  input  logic        i_d_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_misaligned,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t      state;
  logic [CW-1:0] cnt;
  logic        lat_we;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        access;
  logic        aligned;
  logic        idle;
  logic        start;
  logic        cnt_hit;
  logic [31:0] load_data;

  assign access       = i_mem_read | i_mem_write;
  assign aligned      = is_aligned(i_d_size, i_addr[1:0]);
  assign idle         = (state == IDLE);
  assign start        = idle & i_valid & access & aligned;
  assign o_misaligned = idle & i_valid & access & ~aligned;
  assign o_stall      = start | (state == REQ) | (state == RESP);

  // The cycle being spent now is the last one allowed in REQ+RESP.
  assign cnt_hit = (cnt == CW'(TIMEOUT_CYCLES - 2));

  lsu_load_align u_align (
    .rdata         (i_bus_rdata),
    .offset        (lat_off),
    .size          (lat_size),
    .load_unsigned (lat_unsigned),
    .data          (load_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_off      <= 2'b00;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      o_done       <= 1'b0;
      o_rdata      <= 32'h0;
      o_err        <= 1'b0;
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= 32'h0;
      o_bus_be     <= 4'h0;
      o_bus_wdata  <= 32'h0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= REQ;
            cnt          <= '0;
            lat_we       <= i_mem_write;
            lat_off      <= i_addr[1:0];
            lat_size     <= i_d_size;
            lat_unsigned <= i_d_unsigned;
            o_bus_req    <= 1'b1;
            o_bus_we     <= i_mem_write;
            o_bus_addr   <= {i_addr[31:2], 2'b00};
            o_bus_be     <= byte_enable(i_d_size, i_addr[1:0]);
            o_bus_wdata  <= lane_data(i_d_size, i_wdata);
            o_err        <= 1'b0;
            o_rdata      <= 32'h0;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (cnt_hit) begin
            state     <= DONE;
            o_done    <= 1'b1;
            o_err     <= 1'b1;
            o_rdata   <= 32'h0;
            o_bus_req <= 1'b0;
            o_bus_we  <= 1'b0;
          end else if (i_bus_gnt) begin
            state     <= RESP;
            o_bus_req <= 1'b0;
            o_bus_we  <= 1'b0;
          end
        end
        RESP: begin
          cnt <= cnt + 1'b1;
          // A response in the final allowed cycle still counts as completion.
          if (i_bus_rvalid) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_err   <= i_bus_err;
            o_rdata <= (lat_we | i_bus_err) ? 32'h0 : load_data;
          end else if (cnt_hit) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_err   <= 1'b1;
            o_rdata <= 32'h0;
          end
        end
        DONE: begin
          state   <= IDLE;
          o_err   <= 1'b0;
          o_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed table-driven and corner-case checks for lsu_ctrl
module tb_lsu_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [1:0]  i_d_size = 2'b00;
  logic        i_d_unsigned = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_stall, o_done, o_err, o_misaligned, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt = 1'b0;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = 32'h0;
  logic        i_bus_err = 1'b0;

  int n_checks = 0;
  int n_fails = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_d_size(i_d_size), .i_d_unsigned(i_d_unsigned),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done),
    .o_rdata(o_rdata), .o_err(o_err), .o_misaligned(o_misaligned),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata), .i_bus_gnt(i_bus_gnt),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          gnt_delay;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_access(input logic write, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
    i_valid      = 1'b1;
    i_mem_read   = ~write;
    i_mem_write  = write;
    i_d_size     = size;
    i_d_unsigned = uns;
    i_addr       = addr;
    i_wdata      = wdata;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    @(negedge i_clk);
    drive_access(v.write, v.size, v.uns, v.addr, v.wdata);
    #1;
    check({v.name, " stall_t0"}, 32'(o_stall), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int i = 0; i < v.gnt_delay; i++) begin
      check({v.name, " req_wait"}, 32'(o_bus_req), 32'd1);
      check({v.name, " addr_wait"}, o_bus_addr, exp_addr);
      check({v.name, " stall_wait"}, 32'(o_stall), 32'd1);
      @(negedge i_clk);
    end
    check({v.name, " req"}, 32'(o_bus_req), 32'd1);
    check({v.name, " we"}, 32'(o_bus_we), 32'(v.write));
    check({v.name, " addr"}, o_bus_addr, exp_addr);
    check({v.name, " be"}, 32'(o_bus_be), 32'(v.exp_be));
    check({v.name, " bus_wdata"}, o_bus_wdata, v.exp_wdata);
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt = 1'b0;
    check({v.name, " req_resp"}, 32'(o_bus_req), 32'd0);
    check({v.name, " stall_resp"}, 32'(o_stall), 32'd1);
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = v.bus_rdata;
    @(negedge i_clk);
    i_bus_rvalid = 1'b0;
    check({v.name, " done"}, 32'(o_done), 32'd1);
    check({v.name, " rdata"}, o_rdata, v.exp_rdata);
    check({v.name, " err"}, 32'(o_err), 32'd0);
    check({v.name, " stall_done"}, 32'(o_stall), 32'd0);
    @(negedge i_clk);
    check({v.name, " done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int done_at;
    logic        to_err;
    logic [31:0] to_rdata;

    vecs[0] = '{"lb_1003",  1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    vecs[1] = '{"lbu_1003", 1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 4'b1000, 32'h0, 32'h0000_0080};
    vecs[2] = '{"lh_1002",  1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 32'h80FF_0000, 0, 4'b1100, 32'h0, 32'hFFFF_80FF};
    vecs[3] = '{"lhu_1000", 1'b0, 2'b01, 1'b1, 32'h1000, 32'h0, 32'h1234_8001, 0, 4'b0011, 32'h0, 32'h0000_8001};
    vecs[4] = '{"lw_1004",  1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    vecs[5] = '{"lb_1001",  1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 32'h0000_7F00, 0, 4'b0010, 32'h0, 32'h0000_007F};
    vecs[6] = '{"sh_2002",  1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_1234, 32'hFFFF_FFFF, 3, 4'b1100, 32'h1234_1234, 32'h0};
    vecs[7] = '{"sb_2001",  1'b1, 2'b00, 1'b0, 32'h2001, 32'h1234_56A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[8] = '{"sw_2008",  1'b1, 2'b10, 1'b0, 32'h2008, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0};

    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_req", 32'(o_bus_req), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_addr", o_bus_addr, 32'h0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Misaligned word and reserved size: rejected without bus activity.
    @(negedge i_clk);
    drive_access(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0);
    #1;
    check("mis_lw_flag", 32'(o_misaligned), 32'd1);
    check("mis_lw_stall", 32'(o_stall), 32'd0);
    @(negedge i_clk);
    check("mis_lw_req", 32'(o_bus_req), 32'd0);
    i_d_size = 2'b11;
    i_addr   = 32'h3000;
    #1;
    check("mis_sz11_flag", 32'(o_misaligned), 32'd1);
    check("mis_sz11_stall", 32'(o_stall), 32'd0);
    i_valid = 1'b0;
    #1;
    check("mis_invalid", 32'(o_misaligned), 32'd0);

    // Timeout: granted but no response.
    @(negedge i_clk);
    drive_access(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0);
    @(negedge i_clk);
    i_valid   = 1'b0;
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt = 1'b0;
    done_at  = 0;
    to_err   = 1'b0;
    to_rdata = 32'hFFFF_FFFF;
    for (int k = 2; k <= 20; k++) begin
      if (o_done) begin
        done_at  = k;
        to_err   = o_err;
        to_rdata = o_rdata;
        break;
      end
      @(negedge i_clk);
    end
    check("to_done_cycle", 32'(done_at), 32'd8);
    check("to_err", 32'(to_err), 32'd1);
    check("to_rdata", to_rdata, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h1357_9BDF;
    @(negedge i_clk);
    i_bus_rvalid = 1'b0;
    check("to_late_done1", 32'(o_done), 32'd0);
    @(negedge i_clk);
    check("to_late_done2", 32'(o_done), 32'd0);
    check("to_late_stall", 32'(o_stall), 32'd0);

    // Bus error, then a back-to-back load offered during DONE.
    @(negedge i_clk);
    drive_access(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
    @(negedge i_clk);
    i_valid   = 1'b0;
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt    = 1'b0;
    i_bus_rvalid = 1'b1;
    i_bus_err    = 1'b1;
    i_bus_rdata  = 32'hFFFF_FFFF;
    @(negedge i_clk);
    i_bus_rvalid = 1'b0;
    i_bus_err    = 1'b0;
    check("err_done", 32'(o_done), 32'd1);
    check("err_flag", 32'(o_err), 32'd1);
    check("err_rdata", o_rdata, 32'h0);
    drive_access(1'b0, 2'b10, 1'b0, 32'h4004, 32'h0);
    #1;
    check("b2b_no_start_in_done", 32'(o_stall), 32'd0);
    @(negedge i_clk);
    check("b2b_start", 32'(o_stall), 32'd1);
    check("b2b_idle_req", 32'(o_bus_req), 32'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("b2b_req", 32'(o_bus_req), 32'd1);
    check("b2b_addr", o_bus_addr, 32'h4004);
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt    = 1'b0;
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h1122_3344;
    @(negedge i_clk);
    i_bus_rvalid = 1'b0;
    check("b2b_done", 32'(o_done), 32'd1);
    check("b2b_rdata", o_rdata, 32'h1122_3344);
    check("b2b_err", 32'(o_err), 32'd0);

    // Reset while waiting in RESP.
    @(negedge i_clk);
    drive_access(1'b1, 2'b10, 1'b0, 32'h6000, 32'hAAAA_5555);
    @(negedge i_clk);
    i_valid   = 1'b0;
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt = 1'b0;
    i_rst     = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("mrst_req", 32'(o_bus_req), 32'd0);
    check("mrst_we", 32'(o_bus_we), 32'd0);
    check("mrst_stall", 32'(o_stall), 32'd0);
    check("mrst_done", 32'(o_done), 32'd0);
    check("mrst_be", 32'(o_bus_be), 32'd0);
    check("mrst_wdata", o_bus_wdata, 32'h0);
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h0BAD_0BAD;
    @(negedge i_clk);
    i_bus_rvalid = 1'b0;
    check("mrst_late_done1", 32'(o_done), 32'd0);
    @(negedge i_clk);
    check("mrst_late_done2", 32'(o_done), 32'd0);
    check("mrst_rdata", o_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
